// File: rtl/bitwise_seq_ctrl_pkg.sv
// Shared definitions for the bitwise sequencer: opcode values and FSM states.
package bitwise_defs;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_A  = 3'd1,
    ST_RD_B  = 3'd2,
    ST_CAP_B = 3'd3,
    ST_WR    = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/bitwise_seq_ctrl_unit8.sv
// 8-bit bitwise datapath primitives and the op-select wrapper around them.
module and8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  assign y = a & b;
endmodule

module or8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  assign y = a | b;
endmodule

module xor8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  assign y = a ^ b;
endmodule

module not8 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = ~a;
endmodule

module bitwise_unit8
  import bitwise_defs::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] op,
  output logic [7:0] y
);

  logic [7:0] y_and, y_or, y_xor, y_not;

  and8 u_and (.a(a), .b(b), .y(y_and));
  or8  u_or  (.a(a), .b(b), .y(y_or));
  xor8 u_xor (.a(a), .b(b), .y(y_xor));
  not8 u_not (.a(a), .y(y_not));

  // 4:1 result select on the opcode
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = y_and;
      OP_OR:   y = y_or;
      OP_XOR:  y = y_xor;
      default: y = y_not;
    endcase
  end

endmodule

// File: rtl/bitwise_seq_ctrl.sv
// Sequencer walking a byte block through the bitwise datapath via a
// single-port synchronous RAM: read A, read B, capture B, write result.
module bitwise_seq_ctrl
  import bitwise_defs::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        opcode,
  input  logic [ADDR_W-1:0] src_a_base,
  input  logic [ADDR_W-1:0] src_b_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done
);

  state_t            state, state_n;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] a_base_q, b_base_q, d_base_q, len_q, idx;
  logic [7:0]        reg_a, reg_b, result;
  logic              accept, last;

  assign accept = (state == ST_IDLE) && start;
  assign last   = (idx == len_q - ADDR_W'(1));

  bitwise_unit8 u_unit (.a(reg_a), .b(reg_b), .op(op_q), .y(result));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Command latch, byte index and operand capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      d_base_q <= '0;
      len_q    <= '0;
      idx      <= '0;
      reg_a    <= '0;
      reg_b    <= '0;
    end else begin
      if (accept) begin
        op_q     <= opcode;
        a_base_q <= src_a_base;
        b_base_q <= src_b_base;
        d_base_q <= dst_base;
        len_q    <= length;
        idx      <= '0;
      end
      // Read data for the address issued one cycle earlier arrives here
      if (state == ST_RD_B)  reg_a <= mem_rdata;
      if (state == ST_CAP_B) reg_b <= mem_rdata;
      if (state == ST_WR && !last) idx <= idx + ADDR_W'(1);
    end
  end

  // Next-state and RAM/handshake outputs
  always_comb begin
    state_n   = state;
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    busy      = (state != ST_IDLE);
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_n = (length != '0) ? ST_RD_A : ST_DONE;
      end
      ST_RD_A: begin
        mem_addr  = a_base_q + idx;
        mem_rd_en = 1'b1;
        state_n   = ST_RD_B;
      end
      ST_RD_B: begin
        mem_addr  = b_base_q + idx;
        mem_rd_en = 1'b1;
        state_n   = ST_CAP_B;
      end
      ST_CAP_B: state_n = ST_WR;
      ST_WR: begin
        mem_addr  = d_base_q + idx;
        mem_wr_en = 1'b1;
        mem_wdata = result;
        state_n   = last ? ST_DONE : ST_RD_A;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bitwise_seq_ctrl.sv
// Self-checking bench for bitwise_seq_ctrl: a RAM model, a per-cycle expected
// bus-trace built from the operation rules, and directed plus random commands.
module tb_bitwise_seq_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] opcode = 2'b00;
  logic [7:0] src_a_base = '0, src_b_base = '0, dst_base = '0, length = '0;
  logic [7:0] mem_addr, mem_rdata, mem_wdata;
  logic       mem_rd_en, mem_wr_en, busy, done;

  always #5 clock = ~clock;

  bitwise_seq_ctrl #(.ADDR_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode),
    .src_a_base(src_a_base), .src_b_base(src_b_base), .dst_base(dst_base),
    .length(length), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned rd_ptr = 0;
  logic [7:0]  sim_ram [256];
  logic [7:0]  ref_mem [256];
  logic [7:0]  img     [256];
  logic        preload = 1'b0;
  int          checks = 0, errors = 0;
  int          cyc = 0, t0 = 0;
  int          dut_done_cnt = 0, dut_done_cyc = -1;

  function automatic logic [7:0] op_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // RAM: synchronous read with one-cycle latency, write on the edge
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (preload) sim_ram <= img;
    else begin
      if (mem_wr_en) sim_ram[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= sim_ram[mem_addr];
    end
  end

  // Per-cycle compare of all DUT outputs against the expected trace
  always @(negedge clock) begin
    exp_t e, got;
    got = {busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata};
    if (reset) begin
      rd_ptr = exp_q.size();
      e = '0;
    end else if (rd_ptr < exp_q.size()) begin
      e = exp_q[rd_ptr];
      rd_ptr++;
    end else e = '0;
    if (preload) ref_mem = img;
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t got(busy,done,rd,wr,addr,wdata)=%h expected=%h", $time, got, e);
    end
    if (e.wr) ref_mem[e.addr] = e.wdata;
    if (done) begin
      dut_done_cnt++;
      dut_done_cyc = cyc - t0;
    end
  end

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, expv);
    end
  endtask

  task automatic load_ram();
    @(posedge clock); #1 preload = 1'b1;
    @(posedge clock); #1 preload = 1'b0;
  endtask

  // Issue a command and append its expected cycle-by-cycle bus trace
  task automatic start_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] d, input logic [7:0] n);
    logic [7:0] scr [256];
    exp_t e;
    @(posedge clock); #1;
    opcode = op; src_a_base = a; src_b_base = b; dst_base = d; length = n;
    start = 1'b1;
    t0 = cyc;
    scr = ref_mem;
    exp_q.push_back('0);
    for (int i = 0; i < int'(n); i++) begin
      logic [7:0] aa, bb, dd, r;
      aa = a + 8'(i); bb = b + 8'(i); dd = d + 8'(i);
      e = {1'b1, 1'b0, 1'b1, 1'b0, aa, 8'h00}; exp_q.push_back(e);
      e = {1'b1, 1'b0, 1'b1, 1'b0, bb, 8'h00}; exp_q.push_back(e);
      e = {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}; exp_q.push_back(e);
      r = op_ref(op, scr[aa], scr[bb]);
      scr[dd] = r;
      e = {1'b1, 1'b0, 1'b0, 1'b1, dd, r}; exp_q.push_back(e);
    end
    e = {1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00}; exp_q.push_back(e);
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 2000 && rd_ptr < exp_q.size(); k++) @(posedge clock);
    if (rd_ptr < exp_q.size()) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout got=%0d pending expected=0", exp_q.size() - rd_ptr);
    end
  endtask

  initial begin
    logic [7:0] wa[3], wb[3], b0, b1;
    int dc;
    for (int k = 0; k < 256; k++) img[k] = 8'($urandom);
    preload = 1'b1;
    repeat (3) @(posedge clock);
    #1 preload = 1'b0;
    chk("reset_outputs", int'({busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata}), 0);
    reset = 1'b0;

    // OR, N=3
    img[8'h10] = 8'h0F; img[8'h11] = 8'hF0; img[8'h12] = 8'h55;
    img[8'h20] = 8'hF0; img[8'h21] = 8'h0F; img[8'h22] = 8'hAA;
    load_ram();
    dc = dut_done_cnt;
    start_cmd(2'b01, 8'h10, 8'h20, 8'h30, 8'd3);
    wait_idle();
    chk("or_done_cycle", dut_done_cyc, 13);
    chk("or_done_count", dut_done_cnt - dc, 1);
    chk("or_dst0", int'(sim_ram[8'h30]), 8'hFF);
    chk("or_dst1", int'(sim_ram[8'h31]), 8'hFF);
    chk("or_dst2", int'(sim_ram[8'h32]), 8'hFF);

    // XOR and NOT, N=1
    img = sim_ram;
    img[8'h40] = 8'h3C; img[8'h41] = 8'hFF;
    load_ram();
    start_cmd(2'b10, 8'h40, 8'h41, 8'h50, 8'd1);
    wait_idle();
    chk("xor_dst", int'(sim_ram[8'h50]), 8'hC3);
    chk("xor_done_cycle", dut_done_cyc, 5);
    start_cmd(2'b11, 8'h40, 8'h41, 8'h51, 8'd1);
    wait_idle();
    chk("not_dst", int'(sim_ram[8'h51]), 8'hC3);
    chk("not_done_cycle", dut_done_cyc, 5);

    // Length 0
    dc = dut_done_cnt;
    start_cmd(2'b00, 8'h00, 8'h00, 8'h00, 8'd0);
    wait_idle();
    chk("len0_done_cycle", dut_done_cyc, 1);
    chk("len0_done_count", dut_done_cnt - dc, 1);

    // Wrap-around, in-place on A
    img = sim_ram;
    for (int i = 0; i < 3; i++) begin
      wa[i] = img[8'hFE + 8'(i)];
      wb[i] = img[8'(i)];
    end
    start_cmd(2'b00, 8'hFE, 8'h00, 8'hFE, 8'd3);
    wait_idle();
    chk("wrap_fe", int'(sim_ram[8'hFE]), int'(wa[0] & wb[0]));
    chk("wrap_ff", int'(sim_ram[8'hFF]), int'(wa[1] & wb[1]));
    chk("wrap_00", int'(sim_ram[8'h00]), int'(wa[2] & wb[2]));

    // start while busy is dropped
    dc = dut_done_cnt;
    start_cmd(2'b10, 8'h60, 8'h70, 8'h80, 8'd4);
    repeat (5) @(posedge clock);
    #1;
    src_a_base = 8'hA0; src_b_base = 8'hA8; dst_base = 8'hC0; length = 8'd2; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    wait_idle();
    chk("busy_start_done_count", dut_done_cnt - dc, 1);

    // Reset in CAP_B of byte 1
    img = sim_ram;
    b0 = op_ref(2'b01, img[8'h90], img[8'hA0]);
    b1 = img[8'hB1];
    dc = dut_done_cnt;
    start_cmd(2'b01, 8'h90, 8'hA0, 8'hB0, 8'd4);
    repeat (6) @(posedge clock);
    #1 reset = 1'b1;
    #2 chk("reset_midop_busy", int'(busy), 0);
    @(posedge clock); #1 reset = 1'b0;
    wait_idle();
    chk("reset_midop_no_done", dut_done_cnt - dc, 0);
    chk("reset_midop_byte0", int'(sim_ram[8'hB0]), int'(b0));
    chk("reset_midop_byte1", int'(sim_ram[8'hB1]), int'(b1));
    dc = dut_done_cnt;
    start_cmd(2'b00, 8'h90, 8'hA0, 8'hB0, 8'd2);
    wait_idle();
    chk("after_reset_done_count", dut_done_cnt - dc, 1);
    chk("after_reset_done_cycle", dut_done_cyc, 9);

    // Randomized commands
    for (int t = 0; t < 25; t++) begin
      start_cmd(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                (t == 24) ? 8'd60 : 8'($urandom_range(0, 8)));
      wait_idle();
    end

    for (int k = 0; k < 256; k++)
      if (sim_ram[k] !== ref_mem[k]) begin
        checks++;
        errors++;
        $display("FAIL final_ram addr=%0h got=%0h expected=%0h", k, sim_ram[k], ref_mem[k]);
      end else checks++;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
